boot_loader: RTL and testbench

//  Upstream stage of the multi-cycle processor top. Accepts a byte stream from a host link over a

---
 rtl/boot_loader_if.sv | 35 +++
 rtl/boot_loader.sv | 196 +++++++++++++++++++
 tb/tb_boot_loader.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/boot_loader_if.sv
// ---------------------------------------------------------------------------
// boot_loader_if
// Purpose : bundles the host byte handshake and the program-memory write
//           port of the boot loader into one interface.
// Signals :
//   byte_in     host data byte                 (host -> loader)
//   byte_valid  byte_in is valid this cycle    (host -> loader)
//   byte_ready  loader accepts a byte          (loader -> host)
//   mem_we      program-memory write strobe    (loader -> memory)
//   mem_addr    program-memory word address    (loader -> memory)
//   mem_wdata   program-memory write data      (loader -> memory)
// Modports:
//   master  host / memory side (drives the byte stream)
//   slave   the loader itself
// ---------------------------------------------------------------------------
interface boot_loader_if #(
   parameter int ADDR_W = 8
);
   logic [7:0]        byte_in;
   logic              byte_valid;
   logic              byte_ready;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [15:0]       mem_wdata;

   modport master (
      output byte_in, byte_valid,
      input  byte_ready, mem_we, mem_addr, mem_wdata
   );

   modport slave (
      input  byte_in, byte_valid,
      output byte_ready, mem_we, mem_addr, mem_wdata
   );
endinterface

// File: rtl/boot_loader.sv
// ---------------------------------------------------------------------------
// boot_loader
// Purpose : receives a big-endian byte stream from the host (16-bit length N,
//           then N 16-bit words), writes the words into program memory from
//           address 0 upward and holds the processor in reset until the image
//           is complete. Oversized images (N > MAX_WORDS) end in ERR.
// Ports   :
//   clk        system clock, rising edge
//   reset_pin  synchronous active-low reset
//   bus        boot_loader_if.slave (byte handshake + memory write port)
//   cpu_reset  1 = processor held in reset
//   done       image loaded, processor running
//   error      load failed, processor stays in reset
// Config  :
//   BOOT_LOADER_CHECKSUM_EN  when defined, a 16-bit checksum word follows
//                            the data; a mismatch against the mod-2^16 sum
//                            of the data words ends in ERR.
// ---------------------------------------------------------------------------
module boot_loader #(
   parameter int ADDR_W    = 8,
   parameter int MAX_WORDS = 256
) (
   input  logic          clk,
   input  logic          reset_pin,
   boot_loader_if.slave  bus,
   output logic          cpu_reset,
   output logic          done,
   output logic          error
);

   typedef enum logic [3:0] {
      LEN_HI,
      LEN_LO,
      DAT_HI,
      DAT_LO,
      WRITE,
`ifdef BOOT_LOADER_CHECKSUM_EN
      CS_HI,
      CS_LO,
`endif
      RUN,
      ERR
   } state_t;

`ifdef BOOT_LOADER_CHECKSUM_EN
   localparam state_t AFTER_DATA = CS_HI;
`else
   localparam state_t AFTER_DATA = RUN;
`endif

   localparam logic [ADDR_W:0] IDX_ONE = 1;

   state_t            state_q, state_d;
   logic [15:0]       len_q, len_d;
   logic [ADDR_W:0]   idx_q, idx_d;
   logic [7:0]        dataHi_q, dataHi_d;
   logic [ADDR_W-1:0] memAddr_q, memAddr_d;
   logic [15:0]       memWdata_q, memWdata_d;
`ifdef BOOT_LOADER_CHECKSUM_EN
   logic [15:0]       sum_q, sum_d;
`endif

   logic [15:0] newLen;
   logic        xfer;

   assign newLen        = {len_q[15:8], bus.byte_in};
   assign xfer          = bus.byte_valid & bus.byte_ready;
   assign bus.mem_addr  = memAddr_q;
   assign bus.mem_wdata = memWdata_q;

   // State and datapath registers; reset aborts any load in progress and
   // restarts addressing at word 0.
   always_ff @(posedge clk) begin
      if (!reset_pin) begin
         state_q    <= LEN_HI;
         len_q      <= '0;
         idx_q      <= '0;
         dataHi_q   <= '0;
         memAddr_q  <= '0;
         memWdata_q <= '0;
`ifdef BOOT_LOADER_CHECKSUM_EN
         sum_q      <= '0;
`endif
      end else begin
         state_q    <= state_d;
         len_q      <= len_d;
         idx_q      <= idx_d;
         dataHi_q   <= dataHi_d;
         memAddr_q  <= memAddr_d;
         memWdata_q <= memWdata_d;
`ifdef BOOT_LOADER_CHECKSUM_EN
         sum_q      <= sum_d;
`endif
      end
   end

   // Next-state and datapath update. The memory address/data registers are
   // loaded on the low-byte transfer so they are stable through WRITE and
   // keep their values afterwards. idx is one wider than the address so it
   // can reach N == 2**ADDR_W for the last-word comparison.
   always_comb begin
      state_d    = state_q;
      len_d      = len_q;
      idx_d      = idx_q;
      dataHi_d   = dataHi_q;
      memAddr_d  = memAddr_q;
      memWdata_d = memWdata_q;
`ifdef BOOT_LOADER_CHECKSUM_EN
      sum_d      = sum_q;
`endif
      case (state_q)
         LEN_HI: begin
            if (xfer) begin
               len_d[15:8] = bus.byte_in;
               state_d     = LEN_LO;
            end
         end
         LEN_LO: begin
            if (xfer) begin
               len_d = newLen;
               if (newLen == 16'd0) begin
                  state_d = AFTER_DATA;
               end else if (int'(newLen) > MAX_WORDS) begin
                  state_d = ERR;
               end else begin
                  state_d = DAT_HI;
               end
            end
         end
         DAT_HI: begin
            if (xfer) begin
               dataHi_d = bus.byte_in;
               state_d  = DAT_LO;
            end
         end
         DAT_LO: begin
            if (xfer) begin
               memAddr_d  = idx_q[ADDR_W-1:0];
               memWdata_d = {dataHi_q, bus.byte_in};
               state_d    = WRITE;
            end
         end
         WRITE: begin
            idx_d = idx_q + IDX_ONE;
`ifdef BOOT_LOADER_CHECKSUM_EN
            sum_d = sum_q + memWdata_q;
`endif
            if (16'(idx_q + IDX_ONE) == len_q) begin
               state_d = AFTER_DATA;
            end else begin
               state_d = DAT_HI;
            end
         end
`ifdef BOOT_LOADER_CHECKSUM_EN
         CS_HI: begin
            if (xfer) begin
               dataHi_d = bus.byte_in;
               state_d  = CS_LO;
            end
         end
         CS_LO: begin
            if (xfer) begin
               state_d = ({dataHi_q, bus.byte_in} == sum_q) ? RUN : ERR;
            end
         end
`endif
         RUN:     state_d = RUN;
         ERR:     state_d = ERR;
         default: state_d = LEN_HI;
      endcase
   end

   // Outputs decoded from the state. byte_ready and mem_we are gated by
   // reset_pin so nothing is offered or written in a reset cycle.
   always_comb begin
      bus.byte_ready = 1'b0;
      bus.mem_we     = 1'b0;
      cpu_reset      = 1'b1;
      done           = 1'b0;
      error          = 1'b0;
      case (state_q)
         LEN_HI, LEN_LO, DAT_HI, DAT_LO: bus.byte_ready = reset_pin;
`ifdef BOOT_LOADER_CHECKSUM_EN
         CS_HI, CS_LO:                   bus.byte_ready = reset_pin;
`endif
         WRITE:                          bus.mem_we     = reset_pin;
         RUN: begin
            cpu_reset = 1'b0;
            done      = 1'b1;
         end
         ERR:                            error          = 1'b1;
         default: ;
      endcase
   end

endmodule

// File: tb/tb_boot_loader.sv
// ---------------------------------------------------------------------------
// tb_boot_loader
// Purpose : self-checking bench for boot_loader. Images are sent byte by byte
//           and the observed memory writes and final status are compared with
//           what the loading rules predict for each image.
// ---------------------------------------------------------------------------
module tb_boot_loader;

   localparam int ADDR_W    = 8;
   localparam int MAX_WORDS = 256;

   logic clk;
   logic reset_pin;
   logic cpu_reset;
   logic done;
   logic error;

   boot_loader_if #(.ADDR_W(ADDR_W)) bus ();

   boot_loader #(
      .ADDR_W    (ADDR_W),
      .MAX_WORDS (MAX_WORDS)
   ) dut (
      .clk       (clk),
      .reset_pin (reset_pin),
      .bus       (bus),
      .cpu_reset (cpu_reset),
      .done      (done),
      .error     (error)
   );

   int errors = 0;
   int checks = 0;

   logic [ADDR_W-1:0] logAddr[$];
   logic [15:0]       logData[$];
   logic [15:0]       imgWords[$];

   // Free-running clock, 10 time units per cycle.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Every cycle with mem_we high is recorded as one write.
   always @(negedge clk) begin
      if (bus.mem_we === 1'b1) begin
         logAddr.push_back(bus.mem_addr);
         logData.push_back(bus.mem_wdata);
      end
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checks++;
      if (observed !== expected) begin
         errors++;
         $display("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   // Offers one byte and returns on the falling edge after it was taken.
   task automatic applyStimulus(input logic [7:0] b, input bit jitter);
      int guard = 0;
      if (jitter) begin
         repeat ($urandom_range(0, 2)) begin
            bus.byte_valid = 1'b0;
            bus.byte_in    = 8'($urandom);
            @(negedge clk);
         end
      end
      bus.byte_in    = b;
      bus.byte_valid = 1'b1;
      while (bus.byte_ready !== 1'b1 && guard < 200) begin
         @(negedge clk);
         guard++;
      end
      if (guard >= 200) begin
         checkOutput("byte_accept_timeout", 32'd0, 32'd1);
      end else begin
         @(negedge clk);
      end
      bus.byte_valid = 1'b0;
   endtask

   task automatic applyReset(input int cycles);
      reset_pin      = 1'b0;
      bus.byte_valid = 1'b0;
      repeat (cycles) @(negedge clk);
      checkOutput("rst_cpu_reset", 32'(cpu_reset), 32'd1);
      checkOutput("rst_done", 32'(done), 32'd0);
      checkOutput("rst_error", 32'(error), 32'd0);
      checkOutput("rst_mem_we", 32'(bus.mem_we), 32'd0);
      checkOutput("rst_byte_ready", 32'(bus.byte_ready), 32'd0);
      reset_pin = 1'b1;
      @(negedge clk);
      checkOutput("post_rst_byte_ready", 32'(bus.byte_ready), 32'd1);
   endtask

   // Sends an image of n words from imgWords (plus the checksum word in the
   // checksum build, offset by csDelta) and checks outcome and writes.
   task automatic runImage(input int n, input bit jitter, input int csDelta);
      logic [15:0] nWord;
      logic [15:0] sum;
      logic [15:0] cs;
      logic [15:0] w;
      bit          expErr;
      int          expWrites;
      int          delay;
      int          cmpCount;
      nWord = 16'(n);
      sum   = 16'd0;
      applyStimulus(nWord[15:8], jitter);
      applyStimulus(nWord[7:0], jitter);
      if (n > MAX_WORDS) begin
         expErr    = 1'b1;
         expWrites = 0;
         delay     = 0;
      end else begin
         for (int i = 0; i < n; i++) begin
            w   = imgWords[i];
            sum = sum + w;
            applyStimulus(w[15:8], jitter);
            applyStimulus(w[7:0], jitter);
         end
         expWrites = n;
`ifdef BOOT_LOADER_CHECKSUM_EN
         cs = sum + 16'(csDelta);
         applyStimulus(cs[15:8], jitter);
         applyStimulus(cs[7:0], jitter);
         expErr = (16'(csDelta) != 16'd0);
         delay  = 0;
`else
         cs     = 16'(csDelta);
         expErr = 1'b0;
         delay  = (n > 0) ? 1 : 0;
`endif
      end
      if (delay != 0) begin
         checkOutput("done_before_last_write", 32'(done), 32'd0);
         @(negedge clk);
      end
      checkOutput("done", 32'(done), 32'(!expErr));
      checkOutput("error", 32'(error), 32'(expErr));
      checkOutput("cpu_reset", 32'(cpu_reset), 32'(expErr));
      repeat (2) @(negedge clk);
      checkOutput("write_count", 32'(logAddr.size()), 32'(expWrites));
      cmpCount = (logAddr.size() < expWrites) ? logAddr.size() : expWrites;
      for (int i = 0; i < cmpCount; i++) begin
         checkOutput("write_addr", 32'(logAddr[i]), 32'(i));
         checkOutput("write_data", 32'(logData[i]), 32'(imgWords[i]));
      end
      logAddr.delete();
      logData.delete();
   endtask

   initial begin
      reset_pin      = 1'b0;
      bus.byte_valid = 1'b0;
      bus.byte_in    = 8'h00;

      // Reset behaviour.
      applyReset(3);

      // Two-word image, then bytes offered while running are refused.
      imgWords = '{16'h1234, 16'hABCD};
      runImage(2, 1'b0, 0);
      for (int i = 0; i < 6; i++) begin
         bus.byte_in    = 8'($urandom);
         bus.byte_valid = 1'b1;
         @(negedge clk);
         checkOutput("run_byte_ready", 32'(bus.byte_ready), 32'd0);
      end
      bus.byte_valid = 1'b0;
      checkOutput("run_no_writes", 32'(logAddr.size()), 32'd0);
      checkOutput("run_done_held", 32'(done), 32'd1);

      // Oversized length.
      applyReset(2);
      runImage(257, 1'b0, 0);

      // Checksum good / bad (plain images in the default build).
      applyReset(2);
      imgWords = '{16'h0001, 16'h0002};
      runImage(2, 1'b0, 0);
      applyReset(2);
      runImage(2, 1'b0, 1);

      // Same image with random gaps in byte_valid.
      applyReset(2);
      imgWords = '{16'h1234, 16'hABCD};
      runImage(2, 1'b1, 0);

      // Reset in the middle of an image, then a fresh one-word image.
      applyReset(2);
      applyStimulus(8'h00, 1'b0);
      applyStimulus(8'h05, 1'b0);
      applyStimulus(8'h11, 1'b0);
      applyReset(2);
      imgWords = '{16'h55AA};
      runImage(1, 1'b0, 0);

      // Empty image.
      applyReset(2);
      imgWords.delete();
      runImage(0, 1'b0, 0);

      // Largest accepted image.
      applyReset(2);
      imgWords.delete();
      for (int i = 0; i < MAX_WORDS; i++) imgWords.push_back(16'($urandom));
      runImage(MAX_WORDS, 1'b1, 0);

      // Random images, some with a corrupted checksum.
      for (int t = 0; t < 6; t++) begin
         int n;
         int delta;
         applyReset(1 + $urandom_range(0, 2));
         n = $urandom_range(1, 12);
         imgWords.delete();
         for (int i = 0; i < n; i++) imgWords.push_back(16'($urandom));
         delta = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 65535) : 0;
         runImage(n, 1'b1, delta);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
